tmu2_divgen18: RTL

Producer of increment parameters for the TMU2 incremental interpolators: it accepts a start value, an end value and a step count, then computes sign, quotient and remainder of (end − start) / steps with a sequential restoring divider. The result (positive, q, r, divisor, init) is presented on a stb/ack pipeline handshake. The downstream interpolator loads it once per span, then steps through the span with an error accumulator.

---
 rtl/tmu2_divgen18.sv | 115 +++++++++++
 1 files changed

// File: rtl/tmu2_divgen18.sv
// Increment-parameter generator for the TMU2 interpolators: sign, quotient and
// remainder of (end_v - start) / divisor via a 17-step restoring divider.
module tmu2_divgen18 (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pipe_stb_i,
  output logic        pipe_ack_o,
  input  logic [17:0] start,
  input  logic [17:0] end_v,
  input  logic [16:0] divisor,
  output logic        busy,
  output logic        pipe_stb_o,
  input  logic        pipe_ack_i,
  output logic [17:0] init,
  output logic        positive,
  output logic [16:0] q,
  output logic [16:0] r,
  output logic [16:0] divisor_o
);

  localparam int unsigned W  = 18;
  localparam int unsigned DW = 17;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         state;
  logic [DW-1:0]  dividend;
  logic [DW-1:0]  rem;
  logic [CW-1:0]  cnt;

  logic [W:0]     diff_c;
  logic [W:0]     abs_c;
  logic [DW-1:0]  mag_c;
  logic [W-1:0]   rem_sh_c;
  logic           ge_c;
  logic [DW-1:0]  rem_nx_c;

  // Span magnitude (saturated to 17 bits) and one restoring-division step
  always_comb begin
    diff_c   = {end_v[W-1], end_v} - {start[W-1], start};
    abs_c    = diff_c[W] ? ((W+1)'(0) - diff_c) : diff_c;
    mag_c    = (|abs_c[W:DW]) ? {DW{1'b1}} : abs_c[DW-1:0];
    rem_sh_c = {rem, dividend[DW-1]};
    ge_c     = (rem_sh_c >= {1'b0, divisor_o});
    rem_nx_c = ge_c ? DW'(rem_sh_c - {1'b0, divisor_o}) : rem_sh_c[DW-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      pipe_ack_o <= 1'b1;
      busy       <= 1'b0;
      pipe_stb_o <= 1'b0;
      init       <= '0;
      positive   <= 1'b1;
      q          <= '0;
      r          <= '0;
      divisor_o  <= '0;
      dividend   <= '0;
      rem        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pipe_stb_i) begin
            init       <= start;
            divisor_o  <= divisor;
            positive   <= ~diff_c[W];
            pipe_ack_o <= 1'b0;
            busy       <= 1'b1;
            if (divisor == '0) begin
              q          <= '0;
              r          <= '0;
              pipe_stb_o <= 1'b1;
              state      <= DONE;
            end else begin
              dividend <= mag_c;
              rem      <= '0;
              cnt      <= '0;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          dividend <= {dividend[DW-2:0], 1'b0};
          rem      <= rem_nx_c;
          q        <= {q[DW-2:0], ge_c};
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            r          <= rem_nx_c;
            pipe_stb_o <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Outputs stay frozen until downstream takes the result
          if (pipe_ack_i) begin
            pipe_ack_o <= 1'b1;
            busy       <= 1'b0;
            pipe_stb_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          pipe_ack_o <= 1'b1;
          busy       <= 1'b0;
          pipe_stb_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
